// File: rtl/rider_steer_enable_pkg.sv
// Shared types and defaults for the rider steering-enable stage.
// Holds the stance FSM encoding, default weight thresholds and stance timer widths.
package segway_steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_e;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [11:0] WT_HYST_DEF      = 12'h40;

  localparam int TMR_W_FAST = 15;
  localparam int TMR_W_SLOW = 26;

endpackage

// File: rtl/rider_steer_enable_steer_timer.sv
// Stance timer: counts consecutive balanced cycles and flags terminal count.
// Width is 15 bits for fast simulation, 26 bits (~1.34 s at 50 MHz) otherwise.
module steer_timer
  import segway_steer_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic full
);

  localparam int W = FAST_SIM ? TMR_W_FAST : TMR_W_SLOW;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign full = &cnt_q;

endmodule

// File: rtl/rider_steer_enable.sv
// Steering-enable stage: qualifies rider presence and balanced stance from the load cells.
// Optional macro STEER_HYST_EN adds a +/-WT_HYST band around the rider-present threshold.
module rider_steer_enable
  import segway_steer_pkg::*;
#(
  parameter bit          FAST_SIM     = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  output logic        en_steer,
  output logic        rider_off
);

`ifdef STEER_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam logic [12:0] MIN_WT_13 = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] HYST_13   = {1'b0, WT_HYST};
  localparam logic [12:0] HI_THR    = HYST_ON ? (MIN_WT_13 + HYST_13) : MIN_WT_13;
  localparam logic [12:0] LO_THR    = MIN_WT_13 - HYST_13;

  logic [12:0]  sum_d, sum_q;
  logic [11:0]  diff_d, diff_q;
  logic         wt_hi, wt_lo, unbal, step_off;
  steer_state_e state_d, state_q;
  logic         en_steer_q, rider_off_q;
  logic         tmr_inc, tmr_clr, tmr_full;

  assign sum_d  = {1'b0, ld_cell_lft} + {1'b0, ld_cell_rght};
  assign diff_d = (ld_cell_lft >= ld_cell_rght) ? (ld_cell_lft - ld_cell_rght)
                                                : (ld_cell_rght - ld_cell_lft);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      diff_q <= '0;
    end else if (vld) begin
      sum_q  <= sum_d;
      diff_q <= diff_d;
    end
  end

  // Without hysteresis, "present" and "absent" split exactly at MIN_RIDER_WT.
  assign wt_hi    = sum_q > HI_THR;
  assign wt_lo    = HYST_ON ? (sum_q < LO_THR) : (sum_q <= MIN_WT_13);
  assign unbal    = {1'b0, diff_q} > (sum_q >> 2);
  assign step_off = {1'b0, diff_q} > (sum_q - (sum_q >> 4));

  always_comb begin
    state_d = state_q;
    tmr_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (wt_hi) state_d = WAIT;
      end
      WAIT: begin
        if (wt_lo)         state_d = IDLE;
        else if (unbal)    state_d = WAIT;
        else if (tmr_full) state_d = STEER;
        else               tmr_inc = 1'b1;
      end
      STEER: begin
        if (wt_lo)         state_d = IDLE;
        else if (step_off) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Anything other than a balanced WAIT cycle restarts the stance count.
  assign tmr_clr = ~tmr_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      en_steer_q  <= (state_d == STEER);
      rider_off_q <= (state_d == IDLE);
    end
  end

  steer_timer #(
    .FAST_SIM(FAST_SIM)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .inc (tmr_inc),
    .full(tmr_full)
  );

  assign en_steer  = en_steer_q;
  assign rider_off = rider_off_q;

endmodule

// File: tb/tb_rider_steer_enable.sv
// Scoreboard bench for rider_steer_enable (FAST_SIM=1); expectations follow STEER_HYST_EN.
module tb_rider_steer_enable;

`ifdef STEER_HYST_EN
  localparam bit HYST_EXP = 1'b1;
`else
  localparam bit HYST_EXP = 1'b0;
`endif

  typedef struct {
    int    cyc;
    bit    en;
    bit    off;
    string tag;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [11:0] ldCellLft;
  logic [11:0] ldCellRght;
  logic        enSteer;
  logic        riderOff;

  int      cycle = 0;
  int      stimCycle = 0;
  int      assertCount = 0;
  int      failCount = 0;
  expect_t sbQueue[$];

  rider_steer_enable #(
    .FAST_SIM    (1'b1),
    .MIN_RIDER_WT(12'h200),
    .WT_HYST     (12'h40)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vld         (vld),
    .ld_cell_lft (ldCellLft),
    .ld_cell_rght(ldCellRght),
    .en_steer    (enSteer),
    .rider_off   (riderOff)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Drive one load-cell pair with a single-cycle vld strobe.
  task automatic applyStimulus(input logic [11:0] lft, input logic [11:0] rght);
    @(negedge clk);
    stimCycle  = cycle;
    ldCellLft  = lft;
    ldCellRght = rght;
    vld        = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  task automatic checkAt(input int absCyc, input bit en, input bit off, input string tag);
    expect_t e;
    int      idx;
    e.cyc = absCyc;
    e.en  = en;
    e.off = off;
    e.tag = tag;
    idx   = sbQueue.size();
    for (int i = 0; i < sbQueue.size(); i++) begin
      if (sbQueue[i].cyc > absCyc) begin
        idx = i;
        break;
      end
    end
    sbQueue.insert(idx, e);
  endtask

  task automatic checkOutput(input int offset, input bit en, input bit off, input string tag);
    checkAt(stimCycle + offset, en, off, tag);
  endtask

  task automatic waitToCycle(input int target);
    while (cycle < target) @(negedge clk);
  endtask

  // Monitor: compares outputs against due scoreboard entries on the falling edge.
  always @(negedge clk) begin
    expect_t e;
    if (cycle >= 1) begin
      assertCount++;
      if (enSteer && riderOff) begin
        failCount++;
        $display("[TB] FAIL exclusive: en_steer=%0b rider_off=%0b, required not both 1 (cycle %0d)",
                 enSteer, riderOff, cycle);
      end
    end
    while (sbQueue.size() > 0 && sbQueue[0].cyc <= cycle) begin
      e = sbQueue.pop_front();
      assertCount++;
      if (e.cyc < cycle) begin
        failCount++;
        $display("[TB] FAIL %s: check missed at cycle %0d (due %0d)", e.tag, cycle, e.cyc);
      end else if (enSteer !== e.en || riderOff !== e.off) begin
        failCount++;
        $display("[TB] FAIL %s: got en_steer=%0b rider_off=%0b, expected en_steer=%0b rider_off=%0b (cycle %0d)",
                 e.tag, enSteer, riderOff, e.en, e.off, cycle);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, b, r;
    rst        = 1'b1;
    vld        = 1'b1;
    ldCellLft  = 12'd300;
    ldCellRght = 12'd300;
    stimCycle  = 0;
    checkOutput(1, 1'b0, 1'b1, "reset_c1");
    checkOutput(2, 1'b0, 1'b1, "reset_c2");
    checkOutput(3, 1'b0, 1'b1, "reset_c3");
    checkOutput(4, 1'b0, 1'b1, "reset_release");
    checkOutput(5, 1'b0, 1'b1, "reset_after");
    waitToCycle(3);
    rst = 1'b0;
    vld = 1'b0;
    waitToCycle(6);

    $display("[TB] mount 300/300");
    applyStimulus(12'd300, 12'd300);
    checkOutput(1,     1'b0, 1'b1, "mount_pre");
    checkOutput(2,     1'b0, 1'b0, "mount_wait");
    checkOutput(32769, 1'b0, 1'b0, "mount_not_early");
    checkOutput(32770, 1'b1, 1'b0, "mount_steer");
    waitToCycle(stimCycle + 32774);

    $display("[TB] partial step-off");
    applyStimulus(12'd600, 12'd300);
    checkOutput(2,  1'b1, 1'b0, "partial_hold_a");
    checkOutput(20, 1'b1, 1'b0, "partial_hold_b");
    waitToCycle(stimCycle + 22);
    applyStimulus(12'd1000, 12'd20);
    checkOutput(1, 1'b1, 1'b0, "stepoff_part_pre");
    checkOutput(2, 1'b0, 1'b0, "stepoff_part_wait");
    checkOutput(5, 1'b0, 1'b0, "stepoff_part_hold");
    waitToCycle(stimCycle + 10);

    $display("[TB] unbalanced restart");
    applyStimulus(12'd300, 12'd300);
    a = stimCycle;
    checkOutput(2, 1'b0, 1'b0, "rebal_wait");
    waitToCycle(a + 20000);
    applyStimulus(12'd500, 12'd100);
    b = stimCycle;
    checkOutput(500, 1'b0, 1'b0, "unbal_hold");
    checkAt(a + 32769, 1'b0, 1'b0, "unbal_no_early_steer");
    waitToCycle(b + 1000);
    applyStimulus(12'd300, 12'd300);
    r = stimCycle;
    checkOutput(2,     1'b0, 1'b0, "restart_wait");
    checkOutput(32768, 1'b0, 1'b0, "restart_not_early");
    checkOutput(32769, 1'b1, 1'b0, "restart_steer");
    waitToCycle(r + 32772);

    $display("[TB] hysteresis 250/250");
    applyStimulus(12'd250, 12'd250);
    checkOutput(2, HYST_EXP, ~HYST_EXP, "hyst_a");
    checkOutput(6, HYST_EXP, ~HYST_EXP, "hyst_b");
    waitToCycle(stimCycle + 8);

    $display("[TB] step off 350/0");
    applyStimulus(12'd350, 12'd0);
    checkOutput(1, HYST_EXP, ~HYST_EXP, "stepoff_pre");
    checkOutput(2, 1'b0, 1'b1, "stepoff_idle");
    checkOutput(5, 1'b0, 1'b1, "stepoff_hold");
    waitToCycle(stimCycle + 8);

    while (sbQueue.size() > 0) begin
      expect_t e;
      e = sbQueue.pop_front();
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: never checked, due cycle %0d", e.tag, e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rider_steer_enable.md
# rider_steer_enable

Steering-enable stage fed by the two rider load cells. Sums and differences each new load-cell sample and qualifies rider presence with hysteresis. Requires a sustained balanced stance before asserting `en_steer`, and flags `rider_off` when weight drops away. Sits between the A2D load-cell sampling and the balance/steer controller, which uses `en_steer` to gate steerPot steering and `rider_off` to disable drive.

## Interface
- `FAST_SIM`, 1, 1: 15-bit stance timer for simulation; 0: 26-bit timer (~1.34 s at 50 MHz)
- `MIN_RIDER_WT`, 12'h200, nominal rider-present threshold on summed load
- `WT_HYST`, 12'h40, hysteresis half-band around `MIN_RIDER_WT`
- `clk` in 1: system clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `vld` in 1: one-cycle strobe, new load-cell pair valid
- `ld_cell_lft` in 12: left load cell, unsigned
- `ld_cell_rght` in 12: right load cell, unsigned
- `en_steer` out 1: steering enabled, registered
- `rider_off` out 1: no rider on platform, registered

## Operation
- On `vld`:
  - Register `sum` = lft + rght (13 bits, no overflow).
  - Register `diff` = |lft − rght| (12 bits).
- Without `vld`, `sum` and `diff` hold.
- Combinational flags from the registered values (all unsigned, 13-bit compares):
  - `wt_hi`: `sum` > MIN_RIDER_WT + WT_HYST
  - `wt_lo`: `sum` < MIN_RIDER_WT − WT_HYST
  - `unbal`: `diff` > (`sum` >> 2)
  - `step_off`: `diff` > `sum` − (`sum` >> 4)
- FSM states: IDLE, WAIT, STEER.
  - IDLE: `wt_hi` → WAIT, timer cleared.
  - WAIT:
    - `wt_lo` → IDLE.
    - Else `unbal` → stay in WAIT, timer cleared.
    - Else timer at terminal count (all ones) → STEER.
    - Otherwise timer increments.
  - STEER:
    - `wt_lo` → IDLE.
    - Else `step_off` → WAIT, timer cleared.
- Priority: `wt_lo` beats the diff conditions in every state.
- Outputs are decoded from the next state and registered:
  - `en_steer` = (next == STEER)
  - `rider_off` = (next == IDLE)
- Reset values:
  - state IDLE, timer 0, `sum` 0, `diff` 0
  - `en_steer` 0, `rider_off` 1
- Boundaries:
  - `sum` = 0 gives `diff` = 0, so `unbal` and `step_off` are false.
  - The timer is cleared on every entry to WAIT, so it never wraps.
  - A terminal count and `unbal` in the same cycle resolve to a clear (no STEER).
  - `rst` mid-operation returns to IDLE at the next edge, regardless of `vld`.

## Timing
- `vld` sampled at edge N → `sum`/`diff` valid after N.
- State and outputs update at edge N+1.
- `vld`-to-output latency: 2 edges.
- WAIT→STEER takes exactly 2^15 (FAST_SIM=1) or 2^26 consecutive balanced cycles after entering or clearing WAIT.
- `en_steer` and `rider_off` are never both 1.
- Both outputs are glitch-free (flop outputs).

## Configuration
- `STEER_HYST_EN` defined:
  - `wt_hi`/`wt_lo` use the ±WT_HYST band as above.
- `STEER_HYST_EN` undefined:
  - `wt_hi` = `sum` > MIN_RIDER_WT.
  - `wt_lo` = `sum` ≤ MIN_RIDER_WT.
  - WT_HYST is unused.

## Structure
- Package `segway_steer_pkg` holds:
  - state enum `steer_state_e` {IDLE, WAIT, STEER}
  - default constants `MIN_RIDER_WT_DEF`, `WT_HYST_DEF`
- Sub-module `steer_timer`:
  - inputs `clk`, `rst`, `clr`, `inc`
  - output `full`
  - width chosen from FAST_SIM

## Test plan
All scenarios use FAST_SIM=1 with `STEER_HYST_EN` defined unless noted.
- **Reset:** assert `rst` for 3 cycles with loads 300/300 → `en_steer` 0, `rider_off` 1 throughout and after release.
- **Mount:** 300/300 with `vld` (sum 600 > 576) → `rider_off` 0 two edges later. Hold balanced → `en_steer` 1 after 32768 cycles in WAIT, not before.
- **Step off:** in STEER, load 350/0 (sum 350 < 448) → within 2 edges `en_steer` 0, `rider_off` 1.
- **Unbalanced restart:** in WAIT at cycle 20000, load 500/100 (`diff` 400 > 150) for 1000 cycles → `en_steer` stays 0. Return to 300/300 → `en_steer` 1 exactly 32768 cycles after the return sample.
- **Partial step-off:** in STEER, 600/300 → remains STEER. Then 1000/20 (`diff` 980 > 957) → WAIT, `en_steer` 0, `rider_off` 0.
- **Hysteresis:** in STEER, 250/250 (sum 500) → stays STEER with macro defined. With `STEER_HYST_EN` undefined, same stimulus → IDLE, `rider_off` 1.
